// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state set, frame constants and baud helper.
package uart_pkg;

    localparam int unsigned UART_DATA_W    = 8;
    localparam int unsigned UART_STOP_BITS = 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    function automatic int unsigned bit_cycles(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Mid-bit sampling 8N1 receiver: rxd synchronizer, framing FSM and bit/cycle counters.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned BIT = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rxd,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_vld,
    output logic                   frame_err
);

    localparam int unsigned CC_W = (BIT > 1) ? $clog2(BIT) : 1;
    localparam int unsigned BC_W = $clog2(UART_DATA_W);
    localparam logic [CC_W-1:0] CC_HALF = CC_W'(BIT / 2 - 1);
    localparam logic [CC_W-1:0] CC_LAST = CC_W'(BIT - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(UART_DATA_W - 1);

    logic [1:0]             r_sync;
    logic                   w_rs;
    rx_state_t              r_state;
    logic [CC_W-1:0]        r_cc;
    logic [BC_W-1:0]        r_bc;
    logic [UART_DATA_W-1:0] r_shift;
    logic [UART_DATA_W-1:0] r_rx_data;
    logic                   r_rx_vld;
    logic                   r_frame_err;

    assign w_rs      = r_sync[1];
    assign rx_data   = r_rx_data;
    assign rx_vld    = r_rx_vld;
    assign frame_err = r_frame_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync      <= 2'b11;
            r_state     <= IDLE;
            r_cc        <= '0;
            r_bc        <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_vld    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], rxd};
            r_rx_vld    <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_rs) begin
                        r_state <= START;
                        r_cc    <= '0;
                    end
                end
                START: begin
                    // A start bit that is high again at mid-bit is a glitch
                    if (r_cc == CC_HALF) begin
                        if (!w_rs) begin
                            r_state <= DATA;
                            r_cc    <= '0;
                            r_bc    <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cc <= r_cc + CC_W'(1);
                    end
                end
                DATA: begin
                    if (r_cc == CC_LAST) begin
                        r_cc          <= '0;
                        r_shift[r_bc] <= w_rs;
                        if (r_bc == BC_LAST) begin
                            r_state <= STOP;
                        end else begin
                            r_bc <= r_bc + BC_W'(1);
                        end
                    end else begin
                        r_cc <= r_cc + CC_W'(1);
                    end
                end
                STOP: begin
                    if (r_cc == CC_LAST) begin
                        if (w_rs) begin
                            r_rx_vld  <= 1'b1;
                            r_rx_data <= r_shift;
                            r_state   <= IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= BREAK;
                        end
                    end else begin
                        r_cc <= r_cc + CC_W'(1);
                    end
                end
                BREAK: begin
                    // Held-low line: wait for idle so no further frames are decoded
                    if (w_rs) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_monitor.sv
// UART receive monitor: byte history with inactivity blanking and an optional
// valid/ready echo port toward a transmitter.
module uart_rx_monitor
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned BAUD        = 9600,
    parameter int unsigned DEPTH       = 4,
    parameter logic [31:0] HOLD_CYCLES = 32'h01ff_ffff,
    parameter bit          ECHO        = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rxd,
    output logic [UART_DATA_W*DEPTH-1:0] word,
    output logic                         rx_vld,
    output logic [UART_DATA_W-1:0]       rx_data,
    output logic                         frame_err,
    output logic [UART_DATA_W-1:0]       tx_data,
    output logic                         tx_vld,
    input  logic                         tx_rdy,
    output logic                         overrun
);

    localparam int unsigned BIT    = bit_cycles(CLK_HZ, BAUD);
    localparam int unsigned WORD_W = UART_DATA_W * DEPTH;

    logic [UART_DATA_W-1:0] w_rx_data;
    logic                   w_rx_vld;
    logic                   w_frame_err;
    logic [WORD_W-1:0]      r_word;
    logic [31:0]            r_hold;
    logic [UART_DATA_W-1:0] r_tx_data;
    logic                   r_tx_vld;
    logic                   r_overrun;

    uart_rx_core #(
        .BIT(BIT)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .rx_data   (w_rx_data),
        .rx_vld    (w_rx_vld),
        .frame_err (w_frame_err)
    );

    // Shifting by a full byte also covers DEPTH=1, where it degenerates to a load
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_word <= '0;
            r_hold <= '0;
        end else if (w_rx_vld) begin
            r_word <= (r_word << UART_DATA_W) | WORD_W'(w_rx_data);
            r_hold <= HOLD_CYCLES;
        end else if (r_hold != '0) begin
            r_hold <= r_hold - 32'd1;
        end else begin
            r_word <= '0;
        end
    end

    generate
        if (ECHO) begin : g_echo
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_tx_data <= '0;
                    r_tx_vld  <= 1'b0;
                    r_overrun <= 1'b0;
                end else if (w_rx_vld) begin
                    // A handshake in the same cycle frees the slot for the new byte
                    if (!r_tx_vld || tx_rdy) begin
                        r_tx_data <= w_rx_data;
                        r_tx_vld  <= 1'b1;
                    end else begin
                        r_overrun <= 1'b1;
                    end
                end else if (r_tx_vld && tx_rdy) begin
                    r_tx_vld <= 1'b0;
                end
            end
        end else begin : g_no_echo
            assign r_tx_data = '0;
            assign r_tx_vld  = 1'b0;
            assign r_overrun = 1'b0;
        end
    endgenerate

    assign word      = r_word;
    assign rx_vld    = w_rx_vld;
    assign rx_data   = w_rx_data;
    assign frame_err = w_frame_err;
    assign tx_data   = r_tx_data;
    assign tx_vld    = r_tx_vld;
    assign overrun   = r_overrun;

endmodule
